// File: rtl/gsc_pkg.sv
// Shared definitions for the grammar session controller: state and verdict
// encodings, default timing constants and a small width helper.
package gsc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        V_NONE    = 2'd0,
        V_ACCEPT  = 2'd1,
        V_REJECT  = 2'd2,
        V_TIMEOUT = 2'd3
    } verdict_t;

    localparam int DEF_TIMEOUT_CYCLES = 12000;
    localparam int DEF_HOLD_CYCLES    = 6000000;
    localparam int DEF_CNT_W          = 16;

    function automatic int gsc_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gsc_timer.sv
// Up-counting interval timer with synchronous clear, count enable and a
// terminal-count flag. On terminal count it reloads to zero instead of wrapping.
module gsc_timer #(
    parameter int LIMIT = 2,
    parameter int W     = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count;

    assign tc = (count == W'(LIMIT - 1));

    // Count while enabled; clear has priority, terminal count reloads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/grammar_session_ctrl.sv
// Session sequencer between uart_rx and grammar_fsm. Forwards bytes into the
// FSM, ends a session on a verdict or an inter-byte timeout, pulses fsm_rst to
// re-arm the FSM and stretches the verdict onto the LED outputs.
// Optional verdict counters are built when GSC_COUNTERS_EN is defined.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for the first byte of a session
//   ST_ACTIVE | forwarding bytes, watching verdict and inter-byte timeout
//   ST_HOLD   | verdict shown on LEDs, incoming bytes dropped
module grammar_session_ctrl
    import gsc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES
`ifdef GSC_COUNTERS_EN
    ,
    parameter int CNT_W          = DEF_CNT_W
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       fsm_accept,
    input  logic       fsm_reject,
    output logic [7:0] fsm_data,
    output logic       fsm_valid,
    output logic       fsm_rst,
    output logic       led_accept,
    output logic       led_reject,
    output logic       rx_drop,
    output logic       busy
`ifdef GSC_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] accept_count,
    output logic [CNT_W-1:0] reject_count,
    output logic [CNT_W-1:0] timeout_count
`endif
);

    localparam int TW = $clog2(gsc_max(TIMEOUT_CYCLES, HOLD_CYCLES));

    state_t   state;
    verdict_t verdict;
    logic     idle_tc;
    logic     hold_tc;

    // Inter-byte timer: any received byte restarts it; it only runs in ACTIVE.
    gsc_timer #(.LIMIT(TIMEOUT_CYCLES), .W(TW)) u_idle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (rx_valid),
        .en    (state == ST_ACTIVE),
        .tc    (idle_tc)
    );

    // Verdict hold timer: restarted on verdict entry, runs only in HOLD.
    gsc_timer #(.LIMIT(HOLD_CYCLES), .W(TW)) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (verdict != V_NONE),
        .en    (state == ST_HOLD),
        .tc    (hold_tc)
    );

    // Verdict resolution: reject beats accept; a byte arriving on the expiry cycle cancels the timeout.
    always_comb begin
        verdict = V_NONE;
        if (state == ST_ACTIVE) begin
            if (fsm_reject) begin
                verdict = V_REJECT;
            end else if (fsm_accept) begin
                verdict = V_ACCEPT;
            end else if (idle_tc && !rx_valid) begin
                verdict = V_TIMEOUT;
            end
        end
    end

    // Session FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fsm_data   <= '0;
            fsm_valid  <= 1'b0;
            fsm_rst    <= 1'b1;
            led_accept <= 1'b0;
            led_reject <= 1'b0;
            rx_drop    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            fsm_valid <= 1'b0;
            fsm_rst   <= 1'b0;
            rx_drop   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        fsm_data  <= rx_data;
                        fsm_valid <= 1'b1;
                        state     <= ST_ACTIVE;
                        busy      <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (verdict != V_NONE) begin
                        state      <= ST_HOLD;
                        led_accept <= (verdict == V_ACCEPT);
                        led_reject <= (verdict != V_ACCEPT);
                        fsm_rst    <= 1'b1;
                        rx_drop    <= rx_valid;
                    end else if (rx_valid) begin
                        fsm_data  <= rx_data;
                        fsm_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    rx_drop <= rx_valid;
                    if (hold_tc) begin
                        led_accept <= 1'b0;
                        led_reject <= 1'b0;
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GSC_COUNTERS_EN
    // Saturating verdict counters; a timeout counts as a reject too.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            accept_count  <= '0;
            reject_count  <= '0;
            timeout_count <= '0;
        end else begin
            if (verdict == V_ACCEPT && accept_count != '1) begin
                accept_count <= accept_count + 1'b1;
            end
            if ((verdict == V_REJECT || verdict == V_TIMEOUT) && reject_count != '1) begin
                reject_count <= reject_count + 1'b1;
            end
            if (verdict == V_TIMEOUT && timeout_count != '1) begin
                timeout_count <= timeout_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_grammar_session_ctrl.sv
// Directed bench for grammar_session_ctrl with a forwarded-byte scoreboard.
// Counter checks are included when GSC_COUNTERS_EN is defined.
module tb_grammar_session_ctrl;

    localparam int T_CYC = 20;
    localparam int H_CYC = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       fsm_accept;
    logic       fsm_reject;
    logic [7:0] fsm_data;
    logic       fsm_valid;
    logic       fsm_rst;
    logic       led_accept;
    logic       led_reject;
    logic       rx_drop;
    logic       busy;
`ifdef GSC_COUNTERS_EN
    logic [1:0] accept_count;
    logic [1:0] reject_count;
    logic [1:0] timeout_count;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    grammar_session_ctrl #(
        .TIMEOUT_CYCLES (T_CYC),
        .HOLD_CYCLES    (H_CYC)
`ifdef GSC_COUNTERS_EN
        ,
        .CNT_W          (2)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .fsm_accept (fsm_accept),
        .fsm_reject (fsm_reject),
        .fsm_data   (fsm_data),
        .fsm_valid  (fsm_valid),
        .fsm_rst    (fsm_rst),
        .led_accept (led_accept),
        .led_reject (led_reject),
        .rx_drop    (rx_drop),
        .busy       (busy)
`ifdef GSC_COUNTERS_EN
        ,
        .accept_count  (accept_count),
        .reject_count  (reject_count),
        .timeout_count (timeout_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit fwd);
        if (fwd) exp_q.push_back(b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic verdict_step(input bit acc, input bit rej);
        fsm_accept = acc;
        fsm_reject = rej;
        step();
        fsm_accept = 1'b0;
        fsm_reject = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard: every forwarded byte must match the oldest expected one.
    always @(negedge clk) begin
        if (fsm_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_forward", {24'd0, fsm_data}, 32'hFFFF_FFFF);
            end else begin
                check("fwd_data", {24'd0, fsm_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        fsm_accept = 1'b0;
        fsm_reject = 1'b0;

        // reset
        repeat (3) step();
        check("rst_fsm_rst", {31'd0, fsm_rst}, 32'd1);
        check("rst_outs", {26'd0, fsm_valid, led_accept, led_reject, rx_drop, busy, |fsm_data}, 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_release_fsm_rst", {31'd0, fsm_rst}, 32'd0);
        check("rst_release_busy", {31'd0, busy}, 32'd0);

        // accept session
        send("C", 1'b1);
        check("acc_fwd_valid", {31'd0, fsm_valid}, 32'd1);
        check("acc_busy", {31'd0, busy}, 32'd1);
        send("A", 1'b1);
        check("acc_fwd_A", {24'd0, fsm_data}, 32'h41);
        send("T", 1'b1);
        verdict_step(1'b1, 1'b0);
        check("acc_led", {30'd0, led_accept, led_reject}, 32'd2);
        check("acc_fsm_rst", {31'd0, fsm_rst}, 32'd1);
        for (int i = 1; i < H_CYC; i++) begin
            step();
            check("acc_led_hold", {31'd0, led_accept}, 32'd1);
            check("acc_fsm_rst_once", {31'd0, fsm_rst}, 32'd0);
        end
        step();
        check("acc_led_off", {30'd0, led_accept, led_reject}, 32'd0);
        check("acc_idle", {31'd0, busy}, 32'd0);

        // inter-byte timeout
        send("C", 1'b1);
        for (int i = 1; i < T_CYC; i++) begin
            step();
            check("to_not_yet", {31'd0, led_reject}, 32'd0);
        end
        step();
        check("to_led_reject", {30'd0, led_accept, led_reject}, 32'd1);
        check("to_fsm_rst", {31'd0, fsm_rst}, 32'd1);
`ifdef GSC_COUNTERS_EN
        check("to_timeout_count", {30'd0, timeout_count}, 32'd1);
        check("to_reject_count", {30'd0, reject_count}, 32'd1);
        check("to_accept_count", {30'd0, accept_count}, 32'd1);
`endif
        wait_idle("to_end");

        // verdict beats a simultaneous byte
        send("D", 1'b1);
        rx_data  = "X";
        rx_valid = 1'b1;
        verdict_step(1'b0, 1'b1);
        rx_valid = 1'b0;
        check("col_no_fwd", {31'd0, fsm_valid}, 32'd0);
        check("col_drop", {31'd0, rx_drop}, 32'd1);
        check("col_led_reject", {31'd0, led_reject}, 32'd1);
        wait_idle("col_end");

        // byte on the timeout cycle beats the timeout
        send("E", 1'b1);
        repeat (T_CYC - 1) step();
        send("F", 1'b1);
        check("tcol_fwd", {31'd0, fsm_valid}, 32'd1);
        check("tcol_no_verdict", {30'd0, led_accept, led_reject}, 32'd0);
        step();
        check("tcol_still_active", {30'd0, busy, led_reject}, 32'd2);
        verdict_step(1'b1, 1'b0);
        wait_idle("tcol_end");

        // bytes during HOLD are dropped, a byte after HOLD starts a new session
        send("G", 1'b1);
        verdict_step(1'b0, 1'b1);
        send("H", 1'b0);
        check("hold_drop", {30'd0, rx_drop, fsm_valid}, 32'd2);
        step();
        check("hold_drop_pulse", {31'd0, rx_drop}, 32'd0);
        send("I", 1'b0);
        check("hold_drop2", {30'd0, rx_drop, fsm_valid}, 32'd2);
        wait_idle("hold_end");
        send("J", 1'b1);
        check("new_session", {30'd0, fsm_valid, busy}, 32'd3);

        // reset during HOLD
        verdict_step(1'b1, 1'b0);
        repeat (2) step();
        check("mid_led_on", {31'd0, led_accept}, 32'd1);
        rst_n = 1'b0;
        step();
        check("mid_leds_off", {30'd0, led_accept, led_reject}, 32'd0);
        check("mid_fsm_rst", {31'd0, fsm_rst}, 32'd1);
        check("mid_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        step();
        check("mid_release", {31'd0, fsm_rst}, 32'd0);

`ifdef GSC_COUNTERS_EN
        check("cnt_reset", {26'd0, accept_count, reject_count, timeout_count}, 32'd0);
        for (int s = 0; s < 5; s++) begin
            send(8'h30 + 8'(s), 1'b1);
            verdict_step(1'b1, 1'b0);
            wait_idle("sat_session");
        end
        check("cnt_saturate", {30'd0, accept_count}, 32'd3);
`endif

        step();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
